// File: rtl/onehot_token_feeder.sv
// Converts accepted binary index requests into registered one-hot tokens, enforcing the gated-index rule and tracking coverage.
// Optional macro DUP_FILTER_EN: when defined, duplicate indices are consumed silently rather than re-emitted.
module onehot_token_feeder #(
    parameter int WIDTH    = 2016,
    parameter int IDXW     = 11,
    parameter int GATE_IDX = 686,
    parameter int PRE_A    = 2015,
    parameter int PRE_B    = 2000,
    localparam int CW      = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clr,
    input  logic             req_valid,
    input  logic [IDXW-1:0]  req_idx,
    output logic             req_ready,
    output logic [WIDTH-1:0] x,
    output logic             x_valid,
    output logic             err,
    output logic [CW-1:0]    count,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] seen_q, seen_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic             x_valid_q, x_valid_d;
    logic             err_q, err_d;

    logic             accept;
    logic             idx_ok;
    logic             gate_blk;
    logic             dup;
    logic [WIDTH-1:0] hot;

    assign req_ready = (state_q == RUN) && !clr;
    assign accept    = req_valid && req_ready;

    // Out-of-range indices shift the bit off the top, so hot is zero for them.
    assign hot      = WIDTH'(1) << req_idx;
    assign idx_ok   = {{(32-IDXW){1'b0}}, req_idx} < 32'(WIDTH);
    assign gate_blk = ({{(32-IDXW){1'b0}}, req_idx} == 32'(GATE_IDX))
                      && !seen_q[PRE_A] && !seen_q[PRE_B];
    assign dup      = |(seen_q & hot);

    always_comb begin
        state_d   = state_q;
        seen_d    = seen_q;
        count_d   = count_q;
        x_d       = '0;
        x_valid_d = 1'b0;
        err_d     = 1'b0;

        if (accept) begin
            if (!idx_ok || gate_blk) begin
                err_d = 1'b1;
            end else begin
                if (!dup) begin
                    seen_d = seen_q | hot;
                    if (count_q != CW'(WIDTH)) begin
                        count_d = count_q + CW'(1);
                    end
                end
`ifdef DUP_FILTER_EN
                if (!dup) begin
                    x_d       = hot;
                    x_valid_d = 1'b1;
                end
`else
                x_d       = hot;
                x_valid_d = 1'b1;
`endif
            end
        end

        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (count_d == CW'(WIDTH)) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase

        // clr clears coverage but leaves any registered token to drain.
        if (clr) begin
            state_d = IDLE;
            seen_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            seen_q    <= '0;
            count_q   <= '0;
            x_q       <= '0;
            x_valid_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            seen_q    <= seen_d;
            count_q   <= count_d;
            x_q       <= x_d;
            x_valid_q <= x_valid_d;
            err_q     <= err_d;
        end
    end

    assign x       = x_q;
    assign x_valid = x_valid_q;
    assign err     = err_q;
    assign count   = count_q;
    assign done    = (state_q == DONE);

endmodule

// File: tb/tb_onehot_token_feeder.sv
// Bench for onehot_token_feeder: directed scenarios plus randomized traffic checked against a coverage-set reference model.
module tb_onehot_token_feeder;

    localparam int WIDTH    = 2016;
    localparam int IDXW     = 11;
    localparam int GATE_IDX = 686;
    localparam int PRE_A    = 2015;
    localparam int PRE_B    = 2000;
    localparam int CW       = $clog2(WIDTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             clr = 1'b0;
    logic             req_valid = 1'b0;
    logic [IDXW-1:0]  req_idx = '0;
    logic             req_ready;
    logic [WIDTH-1:0] x;
    logic             x_valid;
    logic             err;
    logic [CW-1:0]    count;
    logic             done;

    onehot_token_feeder dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .clr       (clr),
        .req_valid (req_valid),
        .req_idx   (req_idx),
        .req_ready (req_ready),
        .x         (x),
        .x_valid   (x_valid),
        .err       (err),
        .count     (count),
        .done      (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: set of emitted indices plus a phase name.
    bit    seen_m [WIDTH];
    int    cnt_m;
    string phase_m = "unknown";
    bit    exp_xv, exp_err;
    int    exp_xi;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int lowest_one(input logic [WIDTH-1:0] v);
        for (int i = 0; i < WIDTH; i++) if (v[i] === 1'b1) return i;
        return -1;
    endfunction

    task automatic chk_x();
        logic [WIDTH-1:0] want;
        want = '0;
        if (exp_xv) want[exp_xi] = 1'b1;
        total++;
        assert (x === want) else begin
            bad++;
            $error("FAIL x observed_ones=%0d observed_low=%0d expected_valid=%0d expected_idx=%0d",
                   $countones(x), lowest_one(x), exp_xv, exp_xi);
        end
    endtask

    task automatic step(input bit r, input bit s, input bit c, input bit v, input int idx);
        bit ready_m, acc;
        @(negedge clk);
        rst = r; start = s; clr = c; req_valid = v; req_idx = idx[IDXW-1:0];
        #1;
        ready_m = (phase_m == "run") && !c;
        if (phase_m != "unknown") chk("req_ready", {31'b0, req_ready}, {31'b0, ready_m});
        exp_xv = 0; exp_err = 0; exp_xi = 0;
        if (r) begin
            foreach (seen_m[i]) seen_m[i] = 0;
            cnt_m = 0;
            phase_m = "idle";
        end else begin
            acc = v && ready_m;
            if (acc) begin
                if (idx >= WIDTH || (idx == GATE_IDX && !seen_m[PRE_A] && !seen_m[PRE_B])) begin
                    exp_err = 1;
                end else begin
                    bit was = seen_m[idx];
                    if (!was) begin
                        seen_m[idx] = 1;
                        cnt_m++;
                    end
                    exp_xi = idx;
`ifdef DUP_FILTER_EN
                    exp_xv = !was;
`else
                    exp_xv = 1;
`endif
                end
            end
            if (c) begin
                foreach (seen_m[i]) seen_m[i] = 0;
                cnt_m = 0;
                phase_m = "idle";
            end else if (phase_m == "idle" && s) begin
                phase_m = "run";
            end else if (phase_m == "run" && cnt_m == WIDTH) begin
                phase_m = "done";
            end
        end
        @(posedge clk);
        #1;
        chk("x_valid", {31'b0, x_valid}, {31'b0, exp_xv});
        chk("err", {31'b0, err}, {31'b0, exp_err});
        chk("count", 32'(count), 32'(cnt_m));
        chk("done", {31'b0, done}, {31'b0, phase_m == "done"});
        chk_x();
    endtask

    int order [WIDTH];
    int pos;
    int guard;

    initial begin
        // Reset and idle
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 3);
        chk("idle_count", 32'(count), 32'd0);
        chk("idle_ready", {31'b0, req_ready}, 32'd0);

        // Basic emit, gating, range errors, duplicate
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 5);
        chk("first_token_bit5", {31'b0, x[5]}, 32'd1);
        chk("first_count", 32'(count), 32'd1);
        step(0, 0, 0, 1, GATE_IDX);
        chk("gate_err", {31'b0, err}, 32'd1);
        step(0, 0, 0, 1, PRE_B);
        step(0, 0, 0, 1, GATE_IDX);
        chk("gate_open_count", 32'(count), 32'd3);
        step(0, 0, 0, 1, 2016);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 2047);
        step(0, 0, 0, 1, 5);
        chk("dup_count", 32'(count), 32'd3);
        // Same-cycle enable does not count; clr with token in flight
        step(0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 1, PRE_A);
        step(0, 0, 1, 1, 9);
        step(0, 1, 0, 1, GATE_IDX);
        step(0, 0, 0, 1, GATE_IDX);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            int sel, idx;
            sel = $urandom_range(0, 5);
            case (sel)
                0: idx = GATE_IDX;
                1: idx = PRE_A;
                2: idx = PRE_B;
                3: idx = $urandom_range(0, 7);
                4: idx = $urandom_range(2010, 2047);
                default: idx = $urandom_range(0, 2047);
            endcase
            step($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, idx);
        end

        // Full coverage sweep in shuffled order, PRE_A first
        step(0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        order[0] = PRE_A;
        for (int i = 1; i < WIDTH; i++) order[i] = i - 1;
        for (int i = WIDTH - 1; i > 1; i--) begin
            int j, t;
            j = $urandom_range(1, i);
            t = order[i]; order[i] = order[j]; order[j] = t;
        end
        pos = 0;
        guard = 0;
        while (pos < WIDTH && guard < 4 * WIDTH) begin
            bit v;
            v = $urandom_range(0, 3) != 0;
            step(0, 0, 0, v, order[pos]);
            if (v) pos++;
            guard++;
        end
        chk("sweep_within_budget", {31'b0, pos == WIDTH}, 32'd1);
        chk("sweep_done", {31'b0, done}, 32'd1);
        chk("sweep_count", 32'(count), 32'(WIDTH));
        step(0, 0, 0, 1, 7);
        chk("done_ready", {31'b0, req_ready}, 32'd0);
        step(0, 0, 1, 0, 0);
        chk("clr_count", 32'(count), 32'd0);
        chk("clr_done", {31'b0, done}, 32'd0);

        // Reset mid-stream drops the in-flight token
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 11);
        step(1, 0, 0, 1, 12);
        chk("rst_drop", {31'b0, x_valid}, 32'd0);
        step(0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
